seq_pattern_gen: RTL and testbench

- Bit-serial pattern transmitter.
- Loads a PAT_W-bit pattern and a repeat count, then emits the pattern MSB-first, one bit per clock, repeat_n times back-to-back.
- Produces the serial stimulus stream consumed by the team's Mealy/Moore sequence detectors (e.g. pattern 1010).
- Sits upstream of a detector's `in` port; it is the sending end of the detector's serial input.

---
 rtl/seq_gen_pkg.sv | 20 ++
 rtl/seq_pattern_gen_if.sv | 38 +++
 rtl/seq_gen_shifter.sv | 37 +++
 rtl/seq_pattern_gen.sv | 137 +++++++++++++
 tb/tb_seq_pattern_gen.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator:
// the state encoding, default widths and the bit-counter width helper.
package seq_gen_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // A counter that must reach PAT_W-1 needs clog2(PAT_W) bits, never fewer than one.
  function automatic int bitcnt_w(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle between a pattern source (master) and the
// serial generator (slave) that emits the bit stream.
interface seq_pattern_gen_if
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output pattern,
    output repeat_n,
    input  out,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  pattern,
    input  repeat_n,
    output out,
    output out_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/seq_gen_shifter.sv
// MSB-first shift register with a hold copy of the loaded pattern so a
// repetition can restart without going back to the request inputs.
module seq_gen_shifter
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);

  logic [PAT_W-1:0] sreg;
  logic [PAT_W-1:0] hold;

  // Shifting in zeros leaves the register empty after the last bit, so msb idles low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      hold <= '0;
    end else if (load) begin
      sreg <= din;
      hold <= din;
    end else if (reload) begin
      sreg <= hold;
    end else if (shift) begin
      sreg <= {sreg[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = sreg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern transmitter: sends a PAT_W-bit pattern MSB-first,
// repeat_n times. Define SEQ_PATTERN_GEN_GAP_EN for a one-cycle gap between repetitions.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  seq_pattern_gen_if.slave bus
);

  localparam int             BW       = bitcnt_w(PAT_W);
  localparam logic [BW-1:0]  BIT_LAST = BW'(PAT_W - 1);

  state_t           state;
  state_t           state_nx;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bitcnt_nx;
  logic [CNT_W-1:0] repcnt;
  logic [CNT_W-1:0] repcnt_nx;

  logic load;
  logic reload;
  logic shift;
  logic msb;

  logic out_valid_q;
  logic busy_q;
  logic done_q;
  logic out_valid_nx;
  logic busy_nx;
  logic done_nx;

  seq_gen_shifter #(
    .PAT_W (PAT_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .reload (reload),
    .shift  (shift),
    .din    (bus.pattern),
    .msb    (msb)
  );

  // State, counters and the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bitcnt      <= '0;
      repcnt      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      bitcnt      <= bitcnt_nx;
      repcnt      <= repcnt_nx;
      out_valid_q <= out_valid_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    repcnt_nx = repcnt;
    load      = 1'b0;
    reload    = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          repcnt_nx = bus.repeat_n;
          bitcnt_nx = BIT_LAST;
          // A zero-repeat request keeps the shifter empty so out never rises.
          if (bus.repeat_n != '0) begin
            load     = 1'b1;
            state_nx = SHIFT;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SHIFT: begin
        if (bitcnt != '0) begin
          shift     = 1'b1;
          bitcnt_nx = bitcnt - 1'b1;
        end else if (repcnt > CNT_W'(1)) begin
          repcnt_nx = repcnt - 1'b1;
`ifdef SEQ_PATTERN_GEN_GAP_EN
          shift     = 1'b1;
          state_nx  = GAP;
`else
          reload    = 1'b1;
          bitcnt_nx = BIT_LAST;
`endif
        end else begin
          shift     = 1'b1;
          repcnt_nx = '0;
          state_nx  = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      GAP: begin
`ifdef SEQ_PATTERN_GEN_GAP_EN
        reload    = 1'b1;
        bitcnt_nx = BIT_LAST;
        state_nx  = SHIFT;
`else
        state_nx  = IDLE;
`endif
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they register in step with it.
  always_comb begin
    out_valid_nx = (state_nx == SHIFT);
    busy_nx      = (state_nx != IDLE);
    done_nx      = (state_nx == DONE);
  end

  assign bus.out       = msb;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: per-cycle capture of the output
// stream compared against hand-computed masks and bit strings.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

`ifdef SEQ_PATTERN_GEN_GAP_EN
  localparam logic [31:0] A_VALID = 32'h3DEF;
  localparam logic [31:0] A_DONE  = 32'h4000;
  localparam logic [31:0] A_BUSY  = 32'h7FFF;
  localparam logic [31:0] F_VALID = 32'h01EF;
  localparam logic [31:0] F_DONE  = 32'h0200;
  localparam logic [31:0] E_HITS  = 32'd2;
`else
  localparam logic [31:0] A_VALID = 32'h0FFF;
  localparam logic [31:0] A_DONE  = 32'h1000;
  localparam logic [31:0] A_BUSY  = 32'h1FFF;
  localparam logic [31:0] F_VALID = 32'h00FF;
  localparam logic [31:0] F_DONE  = 32'h0100;
  localparam logic [31:0] E_HITS  = 32'd1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_gen #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] vmask;
  logic [31:0] dmask;
  logic [31:0] bmask;
  logic [31:0] stream;
  int          hits   = 0;
  int          hits0;
  logic [1:0]  det_st = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_cap();
    vmask  = '0;
    dmask  = '0;
    bmask  = '0;
    stream = '0;
  endtask

  task automatic sample(input int k);
    @(negedge clk);
    vmask[k] = bus.out_valid;
    dmask[k] = bus.done;
    bmask[k] = bus.busy;
    if (bus.out_valid) stream = {stream[30:0], bus.out};
  endtask

  task automatic capture(input int n);
    clear_cap();
    for (int k = 0; k < n; k++) sample(k);
  endtask

  // Leaves start high for exactly one cycle (cycle N); returns early in cycle N+1.
  task automatic launch(input logic [3:0] pat, input logic [3:0] rep);
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.pattern  = pat;
    bus.repeat_n = rep;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Mealy 1010 detector fed with the gated serial stream.
  always @(negedge clk) begin
    logic din;
    din = bus.out & bus.out_valid;
    if (rst) begin
      det_st <= 2'd0;
    end else begin
      case (det_st)
        2'd0: det_st <= din ? 2'd1 : 2'd0;
        2'd1: det_st <= din ? 2'd1 : 2'd2;
        2'd2: det_st <= din ? 2'd3 : 2'd0;
        default: begin
          det_st <= din ? 2'd1 : 2'd2;
          if (!din) hits <= hits + 1;
        end
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start    = 1'b0;
    bus.pattern  = '0;
    bus.repeat_n = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",       bus.out,       0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      bus.busy,      0);
    check("rst_done",      bus.done,      0);
    rst = 1'b0;

    launch(4'b1010, 4'd3);
    capture(16);
    check("a_valid",  vmask,  A_VALID);
    check("a_done",   dmask,  A_DONE);
    check("a_busy",   bmask,  A_BUSY);
    check("a_stream", stream, 32'hAAA);

    launch(4'b0110, 4'd0);
    capture(4);
    check("b_valid", vmask, 32'h0);
    check("b_done",  dmask, 32'h1);
    check("b_busy",  bmask, 32'h1);

    launch(4'b1010, 4'd1);
    clear_cap();
    for (int k = 0; k < 12; k++) begin
      sample(k);
      @(posedge clk);
      #1;
      case (k)
        1: begin
          bus.start   = 1'b1;
          bus.pattern = 4'b1111;
        end
        2: bus.start = 1'b0;
        3: bus.start = 1'b1;
        5: bus.start = 1'b0;
        default: ;
      endcase
    end
    check("c_valid",  vmask,  32'h3CF);
    check("c_done",   dmask,  32'h410);
    check("c_busy",   bmask,  32'h7DF);
    check("c_stream", stream, 32'hAF);

    launch(4'b1111, 4'd3);
    capture(5);
    @(posedge clk);
    #1;
    check("d_pre_valid", bus.out_valid, 1);
    check("d_pre_out",   bus.out,       1);
    #1;
    rst = 1'b1;
    #1;
    check("d_rst_out",       bus.out,       0);
    check("d_rst_out_valid", bus.out_valid, 0);
    check("d_rst_busy",      bus.busy,      0);
    check("d_rst_done",      bus.done,      0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    capture(16);
    check("d_idle_valid", vmask, 32'h0);
    check("d_idle_done",  dmask, 32'h0);
    launch(4'b1010, 4'd1);
    capture(6);
    check("d_new_valid",  vmask,  32'hF);
    check("d_new_done",   dmask,  32'h10);
    check("d_new_stream", stream, 32'hA);

    hits0 = hits;
    launch(4'b1101, 4'd2);
    capture(12);
    check("e_stream", stream, 32'hDD);
    check("e_hits",   32'(hits - hits0), E_HITS);

    launch(4'b1010, 4'd2);
    capture(12);
    check("f_valid",  vmask,  F_VALID);
    check("f_done",   dmask,  F_DONE);
    check("f_stream", stream, 32'hAA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
